// File: rtl/tx_burst_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_burst_gen_pkg
// Brief    : State encoding and shared 25 MHz timebase constants.
// Revision : 1.0 - initial release
// ============================================================================
package tx_burst_gen_pkg;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_high    = 2'd1;
    localparam logic [1:0] c_st_low     = 2'd2;
    localparam logic [1:0] c_st_holdoff = 2'd3;

    // The debouncer derives its timing from the same clock rate
    localparam int c_clk_hz         = 25_000_000;
    localparam int c_period_cycles  = c_clk_hz / 1000;
    localparam int c_holdoff_cycles = c_clk_hz / 100;

endpackage
`default_nettype wire

// File: rtl/tx_burst_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_burst_gen_if
// Brief    : Trigger input and pulser/status outputs of the burst generator.
// Revision : 1.0 - initial release
// ============================================================================
interface tx_burst_gen_if #(
    parameter int IDX_W = 3
) ();
    logic             en_in;
    logic             tx_pulse;
    logic             busy;
    logic             burst_done;
    logic [IDX_W-1:0] pulse_idx;

    modport master (
        input  en_in,
        output tx_pulse, busy, burst_done, pulse_idx
    );

    modport slave (
        output en_in,
        input  tx_pulse, busy, burst_done, pulse_idx
    );
endinterface
`default_nettype wire

// File: rtl/tx_trigger_arm.sv
`default_nettype none
// ============================================================================
// Module   : tx_trigger_arm
// Brief    : Arms on a low trigger level, fires once per press while idle.
// Revision : 1.0 - initial release
// ============================================================================
module tx_trigger_arm
    import tx_burst_gen_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic       i_en_in,
    input  wire logic [1:0] i_state,
    output logic            o_trigger
);

    logic r_armed;
    logic w_trigger;

    assign w_trigger = (i_state == c_st_idle) && i_en_in && r_armed;
    assign o_trigger = w_trigger;

    // A level held high through reset never fires until it is seen low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= 1'b0;
        end else if (!i_en_in) begin
            r_armed <= 1'b1;
        end else if (w_trigger) begin
            r_armed <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tx_burst_gen
// Brief    : One pulse burst per trigger press, followed by a holdoff period.
// Revision : 1.0 - initial release
// ============================================================================
module tx_burst_gen
    import tx_burst_gen_pkg::*;
#(
    parameter int CNT_W      = 18,
    parameter int PULSE_HI   = 5,
    parameter int PERIOD     = c_period_cycles,
    parameter int NUM_PULSES = 8,
    parameter int HOLDOFF    = c_holdoff_cycles,
    parameter int IDX_W      = 3
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    tx_burst_gen_if.master bus
);

    localparam logic [CNT_W-1:0] c_hi_last   = CNT_W'(PULSE_HI - 1);
    localparam logic [CNT_W-1:0] c_lo_last   = CNT_W'(PERIOD - PULSE_HI - 1);
    localparam logic [CNT_W-1:0] c_hold_last = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;
    localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(NUM_PULSES - 1);
    localparam logic [1:0]       c_after_burst = (HOLDOFF > 0) ? c_st_holdoff : c_st_idle;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic             w_tx_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_trigger;
    logic             w_low_end;
    logic             w_last;

    tx_trigger_arm u_arm (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_en_in   (bus.en_in),
        .i_state   (r_state),
        .o_trigger (w_trigger)
    );

    assign w_low_end = (r_state == c_st_low) && (r_cnt == c_lo_last);
    assign w_last    = (r_idx == c_idx_last);

    // State, phase counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state != c_st_idle) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_idx  <= w_idx_nxt;
            r_tx   <= w_tx_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_trigger) w_state_nxt = c_st_high;
            end
            c_st_high: begin
                if (r_cnt == c_hi_last) w_state_nxt = c_st_low;
            end
            c_st_low: begin
                if (w_low_end) w_state_nxt = w_last ? c_after_burst : c_st_high;
            end
            c_st_holdoff: begin
                if (r_cnt == c_hold_last) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Outputs are decoded from the next state so they align with it once registered
    always_comb begin
        w_tx_nxt   = (w_state_nxt == c_st_high);
        w_busy_nxt = (w_state_nxt != c_st_idle);
        w_done_nxt = w_low_end && w_last;
        w_idx_nxt  = r_idx;
        if (w_state_nxt == c_st_idle) begin
            w_idx_nxt = '0;
        end else if (w_low_end && !w_last) begin
            w_idx_nxt = r_idx + IDX_W'(1);
        end
    end

    assign bus.tx_pulse   = r_tx;
    assign bus.busy       = r_busy;
    assign bus.burst_done = r_done;
    assign bus.pulse_idx  = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_tx_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_burst_gen
// Brief    : Scoreboard bench for tx_burst_gen, with and without holdoff.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tx_burst_gen;

    localparam int c_hi  = 2;
    localparam int c_per = 5;
    localparam int c_np  = 3;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tx_burst_gen_if #(.IDX_W(2)) bus_a ();
    tx_burst_gen_if #(.IDX_W(2)) bus_b ();

    tx_burst_gen #(
        .CNT_W(4), .PULSE_HI(c_hi), .PERIOD(c_per),
        .NUM_PULSES(c_np), .HOLDOFF(4), .IDX_W(2)
    ) dut_a (
        .clk     (clk),
        .reset_n (rst_a_n),
        .bus     (bus_a)
    );

    tx_burst_gen #(
        .CNT_W(4), .PULSE_HI(c_hi), .PERIOD(c_per),
        .NUM_PULSES(c_np), .HOLDOFF(0), .IDX_W(2)
    ) dut_b (
        .clk     (clk),
        .reset_n (rst_b_n),
        .bus     (bus_b)
    );

    typedef struct {
        int         cyc;
        bit         sel;
        int         scn;
        logic [4:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Expected {tx_pulse, busy, burst_done, pulse_idx} k cycles after the trigger cycle
    function automatic logic [4:0] model(int k, int hold);
        logic       tx, bz, dn;
        logic [1:0] ix;
        tx = (k >= 1) && (k <= c_np * c_per) && (((k - 1) % c_per) < c_hi);
        bz = (k >= 1) && (k <= c_np * c_per + hold);
        dn = (k == c_np * c_per + 1);
        ix = 2'd0;
        if (bz) ix = (k <= c_np * c_per) ? 2'((k - 1) / c_per) : 2'(c_np - 1);
        return {tx, bz, dn, ix};
    endfunction

    task automatic push(int c, bit sel, int scn, logic [4:0] e);
        exp_t x;
        x.cyc = c; x.sel = sel; x.scn = scn; x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [4:0] got;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e   = sbq.pop_front();
            got = e.sel ? {bus_b.tx_pulse, bus_b.busy, bus_b.burst_done, bus_b.pulse_idx}
                        : {bus_a.tx_pulse, bus_a.busy, bus_a.burst_done, bus_a.pulse_idx};
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL scn%0d stale entry: expected at cycle %0d, sampled at %0d", e.scn, e.cyc, cyc);
            end else if (got !== e.exp) begin
                errors++;
                $display("FAIL scn%0d dut_%s cycle %0d: tx/busy/done/idx got %b required %b",
                         e.scn, e.sel ? "b" : "a", cyc, got, e.exp);
            end
        end
    end

    initial begin
        int t;
        rst_a_n     = 1'b0;
        rst_b_n     = 1'b0;
        bus_a.en_in = 1'b0;
        bus_b.en_in = 1'b0;

        // Scenario 0: reset state
        step();
        push(cyc, 1'b0, 0, 5'b0);
        push(cyc, 1'b1, 0, 5'b0);
        step();
        push(cyc, 1'b0, 0, 5'b0);
        push(cyc, 1'b1, 0, 5'b0);

        // Scenario 1: basic burst, then button held for a long time
        step();
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(cyc, 1'b0, 1, 5'b0);
            if (i < 2) step();
        end
        step();
        bus_a.en_in = 1'b1;
        t = cyc;
        for (int k = 0; k <= 80; k++) push(t + k, 1'b0, 1, model(k, 4));
        repeat (80) step();

        // Scenario 2: release and re-press during the burst
        bus_a.en_in = 1'b0;
        push(cyc, 1'b0, 2, 5'b0);
        step();
        push(cyc, 1'b0, 2, 5'b0);
        step();
        bus_a.en_in = 1'b1;
        t = cyc;
        for (int k = 0; k <= 45; k++) push(t + k, 1'b0, 2, (k <= 20) ? model(k, 4) : model(k - 20, 4));
        for (int k = 1; k <= 45; k++) begin
            step();
            bus_a.en_in = !(k == 8 || k == 9);
        end

        // Scenario 3: trigger held high through reset
        rst_a_n = 1'b0;
        push(cyc, 1'b0, 3, 5'b0);
        step();
        push(cyc, 1'b0, 3, 5'b0);
        step();
        rst_a_n = 1'b1;
        for (int k = 0; k < 40; k++) push(cyc + k, 1'b0, 3, 5'b0);
        repeat (40) step();
        bus_a.en_in = 1'b0;
        push(cyc, 1'b0, 3, 5'b0);
        step();
        bus_a.en_in = 1'b1;
        t = cyc;
        for (int k = 0; k <= 22; k++) push(t + k, 1'b0, 3, model(k, 4));
        repeat (22) step();

        // Scenario 4: async reset during the second high phase
        bus_a.en_in = 1'b0;
        push(cyc, 1'b0, 4, 5'b0);
        step();
        bus_a.en_in = 1'b1;
        t = cyc;
        for (int k = 0; k <= 6; k++) push(t + k, 1'b0, 4, model(k, 4));
        for (int k = 7; k <= 29; k++) push(t + k, 1'b0, 4, 5'b0);
        repeat (7) step();
        rst_a_n = 1'b0;
        step();
        step();
        rst_a_n = 1'b1;
        repeat (20) step();
        bus_a.en_in = 1'b0;
        push(cyc, 1'b0, 4, 5'b0);
        step();
        bus_a.en_in = 1'b1;
        t = cyc;
        for (int k = 0; k <= 22; k++) push(t + k, 1'b0, 4, model(k, 4));
        repeat (22) step();

        // Scenario 5: zero holdoff, back-to-back bursts
        bus_b.en_in = 1'b1;
        t = cyc;
        for (int k = 0; k <= 40; k++) push(t + k, 1'b1, 5, (k <= 16) ? model(k, 0) : model(k - 16, 0));
        for (int k = 1; k <= 40; k++) begin
            step();
            bus_b.en_in = !(k == 5 || k == 6);
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_burst_gen.md
Name: tx_burst_gen

Overview:
- Consumes the debounced EN trigger level and emits one transmit burst per press: NUM_PULSES pulses, each PULSE_HI cycles high, repeating every PERIOD cycles.
- After the burst, a HOLDOFF dead time runs before the next burst can start.
- Sits between the EN debouncer output and the transducer pulser drive logic.
- Produces busy, done and pulse-index status for the acquisition control.

Parameters:
- CNT_W, 18, width of the phase/holdoff counter; must hold max(PERIOD, HOLDOFF).
- PULSE_HI, 5, high time of each pulse in clk cycles; minimum 1.
- PERIOD, 25000, pulse repetition period in clk cycles (1 ms at 25 MHz); must be > PULSE_HI.
- NUM_PULSES, 8, pulses per burst; minimum 1.
- HOLDOFF, 250000, dead cycles after the burst (10 ms at 25 MHz); 0 is legal.
- IDX_W, 3, pulse_idx width; must be >= clog2(NUM_PULSES), minimum 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en_in  in  1  debounced trigger level; synchronous to clk
- tx_pulse  out  1  transmit pulse to the pulser, registered
- busy  out  1  high while a burst or holdoff is in progress
- burst_done  out  1  one-cycle strobe when the last pulse period ends
- pulse_idx  out  IDX_W  index of the current pulse, 0..NUM_PULSES-1; 0 when idle

Behaviour:
- Reset is asynchronous assert, synchronous deassert (handled externally). In reset: state=IDLE, tx_pulse=0, busy=0, burst_done=0, pulse_idx=0, counters=0, armed=0.
- armed flag:
  - Set on any cycle with en_in=0, in any state.
  - Cleared in the trigger cycle.
  - If en_in is held high through reset, there is no burst until en_in is seen low.
- Trigger: in IDLE with en_in=1 and armed=1 at cycle T, the state is HIGH from T+1. Trigger latency is 1 cycle.
- States:
  - IDLE: outputs low. Leaves only on trigger.
  - HIGH: tx_pulse=1 for exactly PULSE_HI cycles, then LOW.
  - LOW: tx_pulse=0 for PERIOD-PULSE_HI cycles. At the end of LOW:
    - if pulse_idx < NUM_PULSES-1: pulse_idx+1, go to HIGH;
    - otherwise: assert burst_done for the next single cycle, go to HOLDOFF (or IDLE if HOLDOFF=0).
  - HOLDOFF: tx_pulse=0 for HOLDOFF cycles, then IDLE.
- burst_done is high exactly in the first cycle after the last LOW phase, i.e. the first HOLDOFF cycle, or the first IDLE cycle when HOLDOFF=0.
- busy = (state != IDLE); all outputs are registered.
- Burst length: NUM_PULSES*PERIOD cycles; busy is high for NUM_PULSES*PERIOD+HOLDOFF cycles.
- en_in falling mid-burst does not abort the burst; it re-arms.
- A release-then-press during a burst or holdoff leaves armed=1 and en_in=1. The next burst triggers on the first IDLE cycle, so there is one IDLE cycle between bursts.
- Counters:
  - Phase counter is unsigned, CNT_W bits, reloaded to 0 on every state change. No wrap is possible given the parameter constraints.
  - pulse_idx returns to 0 on entry to IDLE.
- Reset mid-operation: tx_pulse drops immediately (async), and no burst_done is produced.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'd0, HIGH=2'd1, LOW=2'd2, HOLDOFF=2'd3) and the default timing constants (25 MHz clock, 10 ms holdoff = 250000 cycles), so the debouncer and the burst generator share one timebase.
- One natural sub-module: tx_trigger_arm (armed flag plus trigger qualification); the FSM and counters stay in tx_burst_gen.

Test Plan:
- Bench parameters for all scenarios: PULSE_HI=2, PERIOD=5, NUM_PULSES=3, HOLDOFF=4, CNT_W=4, IDX_W=2.
- Basic burst: en_in 0 for 3 cycles, then 1 from cycle T -> tx_pulse high at T+1..2, T+6..7, T+11..12; pulse_idx 0,1,2 advancing at T+6 and T+11; burst_done only at T+16; busy T+1..T+19; IDLE at T+20.
- Held button: keep en_in=1 for 60 cycles after the first burst -> exactly one burst; tx_pulse stays 0 after T+12.
- Re-press during burst: en_in low at T+8, high at T+10 -> first burst unchanged; second burst trigger at T+20 with tx_pulse high at T+21..22.
- Power-up held: en_in=1 during and after reset release -> no tx_pulse for 40 cycles. Then en_in 0 for 1 cycle, 1 at cycle S -> burst starts at S+1.
- Reset mid-burst: assert reset_n=0 asynchronously during the second HIGH phase -> tx_pulse, busy and pulse_idx are 0 before the next clk edge; no burst_done; after release, no burst until en_in goes low then high.
- HOLDOFF=0 variant, same other bench parameters: trigger at T -> burst_done at T+16 with busy=0 in that cycle; new trigger accepted at T+16.
